// File: rtl/bus_interrupt_controller.sv
// Four-source bus-mapped interrupt controller: latches requests, masks, arbitrates
// (fixed or round-robin), and steers the processor acknowledge back to the winner.
module bus_interrupt_controller #(
  parameter logic [7:0] BASE_ADDR   = 8'hB0,
  parameter bit         ROUND_ROBIN = 1'b0
) (
  input  logic       CLK,
  input  logic       RESET,
  inout  wire  [7:0] BUS_DATA,
  input  logic [7:0] BUS_ADDR,
  input  logic       BUS_WE,
  input  logic [3:0] SRC_RAISE,
  output logic [3:0] SRC_ACK,
  output logic       CPU_INT_RAISE,
  input  logic       CPU_INT_ACK,
  output logic [1:0] CPU_INT_VECTOR
);

  typedef enum logic [1:0] {S_IDLE, S_RAISE, S_ACK, S_RELEASE} state_t;

  state_t     state;
  state_t     state_next;
  logic [3:0] mask;
  logic [3:0] pending;
  logic [3:0] req;
  logic [3:0] vec_onehot;
  logic [3:0] blocked;
  logic [3:0] set_bits;
  logic [3:0] wr_clr;
  logic [3:0] ack_clr;
  logic [1:0] vec;
  logic [1:0] last;
  logic [1:0] winner;
  logic       in_service;
  logic [7:0] offset;
  logic       in_range;
  logic       wr_en;
  logic       rd_hit;
  logic [7:0] rd_mux;
  logic [7:0] rd_data;
  logic       drive_en;
  logic       unused_bits;

  function automatic logic [1:0] pick_fixed(input logic [3:0] r);
    pick_fixed = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (r[i]) pick_fixed = 2'(i);
    end
  endfunction

  // Scan from offset 4 down to 1 so the nearest set bit after 'prev' is assigned last.
  function automatic logic [1:0] pick_rr(input logic [3:0] r, input logic [1:0] prev);
    logic [1:0] idx;
    pick_rr = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      idx = prev + 2'(k);
      if (r[idx]) pick_rr = idx;
    end
  endfunction

  assign offset      = BUS_ADDR - BASE_ADDR;
  assign in_range    = (offset < 8'd3);
  assign wr_en       = in_range && BUS_WE;
  assign rd_hit      = in_range && !BUS_WE;
  assign unused_bits = ^BUS_DATA[7:4];

  assign req        = pending & mask;
  assign winner     = ROUND_ROBIN ? pick_rr(req, last) : pick_fixed(req);
  assign vec_onehot = 4'b0001 << vec;
  assign in_service = (state != S_IDLE);

  // A source still high while it sees its acknowledge must not re-pend.
  assign blocked  = (state == S_ACK || state == S_RELEASE) ? vec_onehot : 4'b0000;
  assign set_bits = SRC_RAISE & ~blocked;
  assign wr_clr   = (wr_en && offset[1:0] == 2'd1) ? BUS_DATA[3:0] : 4'b0000;
  assign ack_clr  = (state == S_ACK) ? vec_onehot : 4'b0000;

  always_ff @(posedge CLK) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (req != 4'b0000) state_next = S_RAISE;
      S_RAISE:   if (CPU_INT_ACK) state_next = S_ACK;
      S_ACK:     state_next = S_RELEASE;
      S_RELEASE: state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_comb begin
    CPU_INT_RAISE  = (state == S_RAISE);
    CPU_INT_VECTOR = vec;
    SRC_ACK        = 4'b0000;
    if (state == S_ACK) SRC_ACK = vec_onehot;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      mask     <= 4'b0000;
      pending  <= 4'b0000;
      vec      <= 2'd0;
      last     <= 2'd3;
      drive_en <= 1'b0;
    end else begin
      if (wr_en && offset[1:0] == 2'd0) mask <= BUS_DATA[3:0];
      pending <= (pending & ~wr_clr & ~ack_clr) | set_bits;
      if (state == S_IDLE && req != 4'b0000) vec <= winner;
      if (state == S_ACK) last <= vec;
      drive_en <= rd_hit;
    end
  end

  always_comb begin
    rd_mux = 8'h00;
    case (offset[1:0])
      2'd0:    rd_mux = {4'b0000, mask};
      2'd1:    rd_mux = {4'b0000, pending};
      2'd2:    rd_mux = {in_service, 5'b00000, vec};
      default: rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge CLK) begin
    rd_data <= rd_mux;
  end

  assign BUS_DATA = drive_en ? rd_data : 8'hzz;

endmodule

// File: tb/tb_bus_interrupt_controller.sv
// Bench for bus_interrupt_controller: a fixed-priority instance at 0xB0 and a
// round-robin instance at 0xC0 share one pulled-up bus; acknowledges are scoreboarded.
module tb_bus_interrupt_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] addr;
  logic       we;
  logic       tb_oe;
  logic [7:0] tb_wdata;
  wire  [7:0] bus_data;
  logic [3:0] src0, src1;
  wire  [3:0] ack0, ack1;
  logic       cpu_ack0, cpu_ack1;
  wire        raise0, raise1;
  wire  [1:0] vec0, vec1;

  int n_cmp = 0;
  int n_fail = 0;
  int q0[$];
  int q1[$];

  typedef struct {
    logic [3:0] mask;
    logic [3:0] src;
    logic [1:0] vec;
  } vec_t;
  vec_t tbl [8];

  always #5 clk = ~clk;

  assign bus_data = tb_oe ? tb_wdata : 8'hzz;
  for (genvar g = 0; g < 8; g++) begin : g_pull
    pullup pu (bus_data[g]);
  end

  bus_interrupt_controller #(.BASE_ADDR(8'hB0), .ROUND_ROBIN(1'b0)) dut_fixed (
    .CLK(clk), .RESET(rst), .BUS_DATA(bus_data), .BUS_ADDR(addr), .BUS_WE(we),
    .SRC_RAISE(src0), .SRC_ACK(ack0), .CPU_INT_RAISE(raise0),
    .CPU_INT_ACK(cpu_ack0), .CPU_INT_VECTOR(vec0)
  );

  bus_interrupt_controller #(.BASE_ADDR(8'hC0), .ROUND_ROBIN(1'b1)) dut_rr (
    .CLK(clk), .RESET(rst), .BUS_DATA(bus_data), .BUS_ADDR(addr), .BUS_WE(we),
    .SRC_RAISE(src1), .SRC_ACK(ack1), .CPU_INT_RAISE(raise1),
    .CPU_INT_ACK(cpu_ack1), .CPU_INT_VECTOR(vec1)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every acknowledge pulse must match the next expected vector of its instance.
  always @(negedge clk) begin
    if (ack0 != 4'b0000) begin
      if (q0.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL ack0_unexpected: got %b, expected no acknowledge", ack0);
      end else begin
        int e0;
        e0 = q0.pop_front();
        check("ack0_onehot", int'(ack0), 1 << e0);
      end
    end
    if (ack1 != 4'b0000) begin
      if (q1.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL ack1_unexpected: got %b, expected no acknowledge", ack1);
      end else begin
        int e1;
        e1 = q1.pop_front();
        check("ack1_onehot", int'(ack1), 1 << e1);
      end
    end
  end

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    addr = a; we = 1'b1; tb_wdata = d; tb_oe = 1'b1;
    @(negedge clk);
    we = 1'b0; tb_oe = 1'b0; addr = 8'h00;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
    addr = a; we = 1'b0;
    @(negedge clk);
    d = bus_data;
    addr = 8'h00;
    @(negedge clk);
  endtask

  task automatic wait_raise(input bit which, input string name);
    for (int i = 0; i < 20; i++) begin
      if ((which ? raise1 : raise0) == 1'b1) break;
      @(negedge clk);
    end
    check(name, int'(which ? raise1 : raise0), 1);
  endtask

  // Pulse the processor acknowledge; returns at the negedge inside the ACK cycle.
  task automatic pulse_ack(input bit which);
    if (which) cpu_ack1 = 1'b1; else cpu_ack0 = 1'b1;
    @(negedge clk);
    cpu_ack0 = 1'b0; cpu_ack1 = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    tbl[0] = '{4'hF, 4'b1010, 2'd1};
    tbl[1] = '{4'hF, 4'b1111, 2'd0};
    tbl[2] = '{4'hC, 4'b1111, 2'd2};
    tbl[3] = '{4'h8, 4'b1111, 2'd3};
    tbl[4] = '{4'h1, 4'b0001, 2'd0};
    tbl[5] = '{4'hF, 4'b0100, 2'd2};
    tbl[6] = '{4'hA, 4'b1110, 2'd1};
    tbl[7] = '{4'h5, 4'b1100, 2'd2};

    rst = 1'b1; addr = 8'h00; we = 1'b0; tb_oe = 1'b0; tb_wdata = 8'h00;
    src0 = 4'b0; src1 = 4'b0; cpu_ack0 = 1'b0; cpu_ack1 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_raise", int'(raise0), 0);
    check("rst_ack", int'(ack0), 0);
    check("rst_vec", int'(vec0), 0);
    check("rst_bus_idle", int'(bus_data), 8'hFF);
    bus_read(8'hB0, d); check("rst_mask", int'(d), 8'h00);
    bus_read(8'hB1, d); check("rst_pending", int'(d), 8'h00);
    bus_read(8'hB2, d); check("rst_status", int'(d), 8'h00);
    bus_read(8'hC2, d); check("rst_rr_status", int'(d), 8'h00);
    pulse_ack(1'b0);
    @(negedge clk);
    check("idle_ack_ignored", int'(raise0), 0);

    // Single source, basic service, source held through ACK and dropped in RELEASE
    bus_write(8'hB0, 8'h01);
    src0 = 4'b0001;
    @(negedge clk); check("t1_latency1", int'(raise0), 0);
    @(negedge clk); check("t1_raise", int'(raise0), 1);
    check("t1_vec", int'(vec0), 0);
    q0.push_back(0);
    pulse_ack(1'b0);
    check("t1_raise_drop", int'(raise0), 0);
    check("t1_src_ack", int'(ack0), 4'b0001);
    @(negedge clk);
    check("t1_ack_width", int'(ack0), 0);
    src0 = 4'b0000;
    repeat (4) @(negedge clk);
    check("t1_no_second", int'(raise0), 0);
    bus_read(8'hB1, d); check("t1_pending", int'(d), 8'h00);

    // Table of fixed-priority arbitration cases
    for (int t = 0; t < 8; t++) begin
      bus_write(8'hB0, {4'b0, tbl[t].mask});
      src0 = tbl[t].src;
      @(negedge clk); check($sformatf("tbl%0d_lat", t), int'(raise0), 0);
      @(negedge clk); check($sformatf("tbl%0d_raise", t), int'(raise0), 1);
      check($sformatf("tbl%0d_vec", t), int'(vec0), int'(tbl[t].vec));
      src0 = 4'b0000;
      bus_write(8'hB1, 8'h0F);
      check($sformatf("tbl%0d_w1c_keeps", t), int'(raise0), 1);
      check($sformatf("tbl%0d_vec_stable", t), int'(vec0), int'(tbl[t].vec));
      q0.push_back(int'(tbl[t].vec));
      pulse_ack(1'b0);
      repeat (3) @(negedge clk);
      check($sformatf("tbl%0d_idle", t), int'(raise0), 0);
      bus_read(8'hB1, d); check($sformatf("tbl%0d_pending", t), int'(d), 8'h00);
    end

    // Fixed priority with 1010 held, each source drops one cycle after its ack
    bus_write(8'hB0, 8'h0F);
    src0 = 4'b1010;
    wait_raise(1'b0, "fp_raise1");
    check("fp_vec1", int'(vec0), 1);
    q0.push_back(1);
    pulse_ack(1'b0);
    @(negedge clk);
    src0 = 4'b1000;
    wait_raise(1'b0, "fp_raise3");
    check("fp_vec3", int'(vec0), 3);
    q0.push_back(3);
    pulse_ack(1'b0);
    @(negedge clk);
    src0 = 4'b0000;
    repeat (4) @(negedge clk);
    check("fp_done", int'(raise0), 0);

    // Round robin with all sources continuously re-raising
    bus_write(8'hC0, 8'h0F);
    src1 = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_raise(1'b1, $sformatf("rr_raise%0d", k));
      check($sformatf("rr_vec%0d", k), int'(vec1), k % 4);
      if (k == 4) begin
        src1 = 4'b0000;
        bus_write(8'hC1, 8'h0F);
      end
      q1.push_back(k % 4);
      pulse_ack(1'b1);
    end
    repeat (4) @(negedge clk);
    check("rr_done", int'(raise1), 0);

    // Masked pending is retained and fires when unmasked
    bus_write(8'hB0, 8'h00);
    src0 = 4'b0100;
    repeat (2) @(negedge clk);
    bus_read(8'hB1, d); check("mask_pending", int'(d), 8'h04);
    check("mask_no_raise", int'(raise0), 0);
    src0 = 4'b0000;
    bus_write(8'hB0, 8'h04);
    wait_raise(1'b0, "unmask_raise");
    check("unmask_vec", int'(vec0), 2);
    q0.push_back(2);
    pulse_ack(1'b0);
    repeat (3) @(negedge clk);

    // Clearing the masked pending bit before unmasking prevents the interrupt
    bus_write(8'hB0, 8'h00);
    src0 = 4'b0100;
    repeat (2) @(negedge clk);
    src0 = 4'b0000;
    bus_write(8'hB1, 8'h04);
    bus_write(8'hB0, 8'h04);
    repeat (3) @(negedge clk);
    check("w1c_no_raise", int'(raise0), 0);
    bus_read(8'hB1, d); check("w1c_pending", int'(d), 8'h00);

    // Status read during service of source 3; decode boundaries
    bus_write(8'hB0, 8'h08);
    src0 = 4'b1000;
    wait_raise(1'b0, "st_raise");
    bus_read(8'hB2, d); check("st_status", int'(d), 8'h83);
    bus_read(8'hB3, d); check("st_b3_undriven", int'(d), 8'hFF);
    bus_read(8'hA0, d); check("st_a0_undriven", int'(d), 8'hFF);
    bus_write(8'hB2, 8'h00);
    bus_read(8'hB2, d); check("st_readonly", int'(d), 8'h83);
    src0 = 4'b0000;
    q0.push_back(3);
    pulse_ack(1'b0);
    repeat (3) @(negedge clk);
    check("st_done", int'(raise0), 0);

    // Reset while in RAISE
    bus_write(8'hB0, 8'h01);
    src0 = 4'b0001;
    wait_raise(1'b0, "rst_mid_raise");
    rst = 1'b1;
    src0 = 4'b0000;
    @(negedge clk);
    check("rst_mid_raise_low", int'(raise0), 0);
    check("rst_mid_ack_low", int'(ack0), 0);
    rst = 1'b0;
    @(negedge clk);
    bus_read(8'hB0, d); check("rst_mid_mask", int'(d), 8'h00);
    bus_read(8'hB1, d); check("rst_mid_pending", int'(d), 8'h00);
    repeat (5) @(negedge clk);
    check("rst_mid_no_stale", int'(raise0), 0);

    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
